// File: rtl/simple_micro_div_pkg.sv
// Shared types and constants for the simple_micro_div sequential restoring divider.
package simple_micro_div_pkg;

    localparam int DVD_W    = 8;
    localparam int DVS_W    = 4;
    localparam int DIV_ITER = 8;

    localparam logic [DVD_W-1:0] Q_DZ = 8'hFF;
    localparam logic [DVS_W-1:0] R_DZ = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: one shift/compare/subtract step per enabled clock.
module div_datapath
    import simple_micro_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [DVD_W-1:0] d_in,
    input  logic [DVS_W-1:0] v_in,
    output logic [DVD_W-1:0] q_nxt,
    output logic [DVS_W-1:0] r_nxt
);

    logic [DVD_W-1:0] qreg_q, qreg_d;
    logic [DVS_W-1:0] vreg_q, vreg_d;
    // The 5-bit partial remainder's MSB is always zero between steps
    // (the result of a step never exceeds the 4-bit divisor), so only 4 bits are stored.
    logic [DVS_W-1:0] preg_q, preg_d;

    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;
    logic             fits;

    always_comb begin
        trial  = {preg_q, qreg_q[DVD_W-1]};
        diff   = trial - {1'b0, vreg_q};
        fits   = (trial >= {1'b0, vreg_q});
        qreg_d = qreg_q;
        vreg_d = vreg_q;
        preg_d = preg_q;
        if (load) begin
            qreg_d = d_in;
            vreg_d = v_in;
            preg_d = '0;
        end else if (step) begin
            qreg_d = {qreg_q[DVD_W-2:0], fits};
            preg_d = fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qreg_q <= '0;
            vreg_q <= '0;
            preg_q <= '0;
        end else begin
            qreg_q <= qreg_d;
            vreg_q <= vreg_d;
            preg_q <= preg_d;
        end
    end

    // Exposed so the result registers can capture the 8th step on the same edge it completes.
    assign q_nxt = qreg_d;
    assign r_nxt = preg_d;

endmodule

// File: rtl/simple_micro_div.sv
// 8-by-4 unsigned sequential divider: control FSM, iteration counter and held result registers.
module simple_micro_div
    import simple_micro_div_pkg::*;
(
    input  logic             sys_clk,
    input  logic             nsys_rst,
    input  logic             start,
    input  logic [DVD_W-1:0] D,
    input  logic [DVS_W-1:0] V,
    output logic [DVD_W-1:0] Q,
    output logic [DVS_W-1:0] R,
    output logic             dz,
    output logic             done,
    output logic             busy
);

    div_state_t       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [DVD_W-1:0] q_q, q_d;
    logic [DVS_W-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic             dp_load;
    logic             dp_step;
    logic [DVD_W-1:0] dp_q_nxt;
    logic [DVS_W-1:0] dp_r_nxt;

    div_datapath u_datapath (
        .clk   (sys_clk),
        .rst_n (nsys_rst),
        .load  (dp_load),
        .step  (dp_step),
        .d_in  (D),
        .v_in  (V),
        .q_nxt (dp_q_nxt),
        .r_nxt (dp_r_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (V != '0) begin
                        dp_load = 1'b1;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        q_d     = Q_DZ;
                        r_d     = R_DZ;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'(DIV_ITER - 1)) begin
                    q_d     = dp_q_nxt;
                    r_d     = dp_r_nxt;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge nsys_rst) begin
        if (!nsys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;
    assign done = (state_q == DONE);
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_simple_micro_div.sv
// Directed and exhaustive checks for simple_micro_div against hand-computed results.
module tb_simple_micro_div;

    logic       sys_clk;
    logic       nsys_rst;
    logic       start;
    logic [7:0] D;
    logic [3:0] V;
    logic [7:0] Q;
    logic [3:0] R;
    logic       dz;
    logic       done;
    logic       busy;

    int n_checks;
    int n_pass;

    simple_micro_div dut (
        .sys_clk  (sys_clk),
        .nsys_rst (nsys_rst),
        .start    (start),
        .D        (D),
        .V        (V),
        .Q        (Q),
        .R        (R),
        .dz       (dz),
        .done     (done),
        .busy     (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Issues one operation from IDLE; returns edges from accept to done, the Q seen
    // right after the accepting edge, and whether the unit is idle one edge after done.
    task automatic do_op(input logic [7:0] d, input logic [3:0] v,
                         output int lat, output logic [7:0] q_after_accept,
                         output logic idle_after);
        @(negedge sys_clk);
        D = d; V = v; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        q_after_accept = Q;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        @(posedge sys_clk); #1;
        idle_after = !busy && !done;
        @(posedge sys_clk); #1;
    endtask

    task automatic directed(input logic [7:0] d, input logic [3:0] v,
                            input logic [7:0] eq, input logic [3:0] er, input logic edz,
                            input int elat, input logic [7:0] prev_q);
        int         lat;
        logic [7:0] qa;
        logic       idle_after;
        do_op(d, v, lat, qa, idle_after);
        $display("op D=%0d V=%0d -> Q=%0d R=%0d dz=%0d lat=%0d", d, v, Q, R, dz, lat);
        check_eq($sformatf("q_%0d_%0d", d, v), 32'(Q), 32'(eq));
        check_eq($sformatf("r_%0d_%0d", d, v), 32'(R), 32'(er));
        check_eq($sformatf("dz_%0d_%0d", d, v), 32'(dz), 32'(edz));
        check_eq($sformatf("lat_%0d_%0d", d, v), 32'(lat), 32'(elat));
        check_eq($sformatf("idle_%0d_%0d", d, v), 32'(idle_after), 32'd1);
        if (elat != 0) check_eq($sformatf("hold_%0d_%0d", d, v), 32'(qa), 32'(prev_q));
    endtask

    initial begin
        int         lat;
        int         cyc;
        logic [7:0] qa;
        logic       idle_after;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;

        n_checks = 0;
        n_pass   = 0;
        nsys_rst = 1'b0;
        start    = 1'b0;
        D        = '0;
        V        = '0;
        #1;
        check_eq("rst_q", 32'(Q), 32'd0);
        check_eq("rst_r", 32'(R), 32'd0);
        check_eq("rst_flags", {29'd0, dz, done, busy}, 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        nsys_rst = 1'b1;

        directed(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 8'd0);
        directed(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, 8'd28);
        directed(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8, 8'd255);
        directed(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8, 8'd17);
        directed(8'd77, 4'd0, 8'hFF, 4'hF, 1'b1, 0, 8'd0);
        directed(8'd77, 4'd4, 8'd19, 4'd1, 1'b0, 8, 8'hFF);

        // A second start mid-CALC must be ignored.
        @(negedge sys_clk);
        D = 8'd200; V = 4'd7; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        D = 8'd13; V = 4'd3; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge sys_clk);
            cyc++;
        end
        $display("op midcalc-start D=200 V=7 -> Q=%0d R=%0d dz=%0d", Q, R, dz);
        check_eq("midcalc_done", 32'(done), 32'd1);
        check_eq("midcalc_qr", {20'd0, Q, R}, {20'd0, 8'd28, 4'd4});
        @(negedge sys_clk);
        @(negedge sys_clk);

        // start held high: back-to-back operations ten cycles apart.
        D = 8'd100; V = 4'd10; start = 1'b1;
        cyc = 0;
        do begin
            @(posedge sys_clk); #1;
            cyc++;
        end while (!done && cyc < 30);
        check_eq("held_q1", 32'(Q), 32'd10);
        cyc = 0;
        do begin
            @(posedge sys_clk); #1;
            cyc++;
        end while (!done && cyc < 30);
        $display("op held-start D=100 V=10 -> Q=%0d R=%0d spacing=%0d", Q, R, cyc);
        check_eq("held_spacing", 32'(cyc), 32'd10);
        check_eq("held_r2", 32'(R), 32'd0);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 30) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        check_eq("held_idle", 32'(busy), 32'd0);

        // Asynchronous reset during the 4th iteration aborts with all outputs cleared.
        @(negedge sys_clk);
        D = 8'd200; V = 4'd7; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        nsys_rst = 1'b0;
        #1;
        $display("op reset-mid-calc -> Q=%0d R=%0d dz=%0d busy=%0d", Q, R, dz, busy);
        check_eq("abort_q", 32'(Q), 32'd0);
        check_eq("abort_flags", {28'd0, R == 4'd0, dz, done, busy}, 32'd8);
        @(negedge sys_clk);
        nsys_rst = 1'b1;
        directed(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8, 8'd0);

        // Exhaustive sweep against a behavioural reference.
        for (int d = 0; d < 256; d++) begin
            for (int v = 0; v < 16; v++) begin
                do_op(8'(d), 4'(v), lat, qa, idle_after);
                if (v == 0) begin
                    eq = 8'hFF; er = 4'hF; edz = 1'b1;
                end else begin
                    eq = 8'(d / v); er = 4'(d % v); edz = 1'b0;
                end
                check_eq($sformatf("sweep_%0d_%0d", d, v), {19'd0, Q, R, dz}, {19'd0, eq, er, edz});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
